// File: rtl/sync_fifo_prog_if.sv
// Handshake/status bundle for sync_fifo_prog: the bench or producer drives the master side, the FIFO sits on the slave side.
interface sync_fifo_prog_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
);
    logic                  flush;
    logic                  wr_en;
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [CNT_W-1:0]      af_thresh;
    logic [CNT_W-1:0]      ae_thresh;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CNT_W-1:0]      count;

    modport master (
        output flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
        input  data_out, rd_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
        output data_out, rd_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with runtime almost-full/empty thresholds and any depth >= 2.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_prog_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [FIFO_WIDTH-1:0] dout_q;
    logic                  wr_ack_q, ovf_q, udf_q;
    logic                  empty;
    logic                  rd_acc, wr_acc;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count == '0);
    assign rd_acc = bus.rd_en && !empty;
    assign wr_acc = bus.wr_en && ((count < DEPTH_C) || rd_acc);

    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && wr_acc)
            mem[wr_ptr] <= bus.data_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // dout_q holds the last word shown, so data_out stays put while empty.
    always_ff @(posedge clk) begin
        if (rst)
            dout_q <= '0;
        else if (!empty && (bus.flush || rd_acc))
            dout_q <= mem[rd_ptr];
    end
    assign bus.data_out = empty ? dout_q : mem[rd_ptr];
    assign bus.rd_valid = !empty;
`else
    logic rd_vld_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q   <= '0;
            rd_vld_q <= 1'b0;
        end else if (bus.flush) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_acc;
            if (rd_acc)
                dout_q <= mem[rd_ptr];
        end
    end
    assign bus.data_out = dout_q;
    assign bus.rd_valid = rd_vld_q;
`endif

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ack_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ack_q <= wr_acc;
            ovf_q    <= bus.wr_en && !wr_acc;
            udf_q    <= bus.rd_en && !rd_acc;
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = udf_q;
    assign bus.count       = count;
    assign bus.empty       = empty;
    assign bus.full        = (count == DEPTH_C);
    assign bus.almostfull  = (count >= bus.af_thresh);
    assign bus.almostempty = (count <= bus.ae_thresh);
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed plus scoreboarded random bench for sync_fifo_prog (depth 6, width 16); works in both read modes.
module tb_sync_fifo_prog;
    localparam int W = 16;
    localparam int D = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    sync_fifo_prog_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus ();
    sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pops one word and checks it against exp at the mode's read latency.
    task automatic read_chk(input string tag, input logic [W-1:0] exp);
        bus.rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
        #1;
        chk({tag, "_data"}, 32'(bus.data_out), 32'(exp));
        chk({tag, "_vld"}, 32'(bus.rd_valid), 32'd1);
        step();
`else
        step();
        chk({tag, "_data"}, 32'(bus.data_out), 32'(exp));
        chk({tag, "_vld"}, 32'(bus.rd_valid), 32'd1);
`endif
        bus.rd_en = 1'b0;
    endtask

    task automatic write(input logic [W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.data_in = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    logic [W-1:0] q[$];
    logic [W-1:0] head;
    logic [W-1:0] exp_hold;
    logic         r_wr, r_rd, r_wok, r_rok;

    initial begin
        bus.flush = 0; bus.wr_en = 0; bus.rd_en = 0; bus.data_in = '0;
        bus.af_thresh = 3'd5; bus.ae_thresh = 3'd1;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_ae", 32'(bus.almostempty), 1);
        chk("rst_af", 32'(bus.almostfull), 0);
        chk("rst_ack", 32'(bus.wr_ack), 0);
        chk("rst_vld", 32'(bus.rd_valid), 0);
        chk("rst_dout", 32'(bus.data_out), 0);

        // Fill to full
        for (int i = 1; i <= D; i++) begin
            write(W'(i));
            chk("fill_ack", 32'(bus.wr_ack), 1);
            chk("fill_count", 32'(bus.count), 32'(i));
            chk("fill_af", 32'(bus.almostfull), (i >= 5) ? 32'd1 : 32'd0);
            chk("fill_full", 32'(bus.full), (i == D) ? 32'd1 : 32'd0);
        end

        // Overflow: rejected write must not land
        write(16'hDEAD);
        chk("ovf_flag", 32'(bus.overflow), 1);
        chk("ovf_ack", 32'(bus.wr_ack), 0);
        chk("ovf_count", 32'(bus.count), 6);
        step();
        chk("ovf_clear", 32'(bus.overflow), 0);

        // Simultaneous write+read while full
        bus.wr_en = 1'b1; bus.data_in = 16'h0007;
        read_chk("full_rw", 16'h0001);
        bus.wr_en = 1'b0;
        chk("full_rw_ack", 32'(bus.wr_ack), 1);
        chk("full_rw_count", 32'(bus.count), 6);
        for (int i = 2; i <= 7; i++) read_chk("drain", W'(i));
        chk("drain_empty", 32'(bus.empty), 1);
        step();
`ifndef SYNC_FIFO_FWFT_EN
        chk("vld_pulse", 32'(bus.rd_valid), 0);
`endif
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        chk("udf_flag", 32'(bus.underflow), 1);

        // Write+read on empty: write wins, read rejected
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.data_in = 16'h00AA;
        step();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        chk("ew_udf", 32'(bus.underflow), 1);
        chk("ew_ack", 32'(bus.wr_ack), 1);
        chk("ew_count", 32'(bus.count), 1);
        read_chk("ew_read", 16'h00AA);

        // Flush at count 4 with a concurrent write
        for (int i = 0; i < 4; i++) write(W'(16'h0010 + i));
        chk("pre_flush_count", 32'(bus.count), 4);
`ifdef SYNC_FIFO_FWFT_EN
        exp_hold = 16'h0010;
`else
        exp_hold = 16'h00AA;
`endif
        bus.flush = 1'b1; bus.wr_en = 1'b1; bus.data_in = 16'h00BB;
        step();
        bus.flush = 1'b0; bus.wr_en = 1'b0;
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_empty", 32'(bus.empty), 1);
        chk("flush_ack", 32'(bus.wr_ack), 0);
        chk("flush_dout", 32'(bus.data_out), 32'(exp_hold));
        write(16'h0055);
        read_chk("post_flush", 16'h0055);

        // Runtime threshold edges
        bus.af_thresh = 3'd0; #1;
        chk("af_zero", 32'(bus.almostfull), 1);
        bus.af_thresh = 3'd7; #1;
        chk("af_over", 32'(bus.almostfull), 0);
        write(16'h0123);
        bus.ae_thresh = 3'd0; #1;
        chk("ae_zero", 32'(bus.almostempty), 0);
        bus.af_thresh = 3'd1; #1;
        chk("af_one", 32'(bus.almostfull), 1);
        bus.af_thresh = 3'd5; bus.ae_thresh = 3'd1;
        read_chk("thr_read", 16'h0123);

        // Random traffic across pointer wraps
        for (int n = 0; n < 200; n++) begin
            r_wr = 1'($urandom_range(0, 1));
            r_rd = 1'($urandom_range(0, 1));
            r_rok = r_rd && (q.size() > 0);
            r_wok = r_wr && ((q.size() < D) || r_rok);
            bus.wr_en = r_wr; bus.rd_en = r_rd; bus.data_in = W'($urandom);
            head = (q.size() > 0) ? q[0] : '0;
`ifdef SYNC_FIFO_FWFT_EN
            #1;
            if (r_rok) chk("rnd_data", 32'(bus.data_out), 32'(head));
`endif
            if (r_rok) void'(q.pop_front());
            if (r_wok) q.push_back(bus.data_in);
            step();
`ifndef SYNC_FIFO_FWFT_EN
            if (r_rok) chk("rnd_data", 32'(bus.data_out), 32'(head));
            chk("rnd_vld", 32'(bus.rd_valid), 32'(r_rok));
`endif
            chk("rnd_ack", 32'(bus.wr_ack), 32'(r_wok));
            chk("rnd_ovf", 32'(bus.overflow), 32'(r_wr && !r_wok));
            chk("rnd_udf", 32'(bus.underflow), 32'(r_rd && !r_rok));
            chk("rnd_count", 32'(bus.count), 32'(q.size()));
        end
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;

        // Reset mid-burst discards contents
        write(16'h0101);
        rst = 1'b1; bus.wr_en = 1'b1; bus.data_in = 16'h0202;
        step();
        rst = 1'b0; bus.wr_en = 1'b0;
        chk("mrst_count", 32'(bus.count), 0);
        chk("mrst_empty", 32'(bus.empty), 1);
        chk("mrst_dout", 32'(bus.data_out), 0);
        chk("mrst_ack", 32'(bus.wr_ack), 0);
        write(16'h0077);
        read_chk("mrst_read", 16'h0077);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, data word width in bits (>=1).
REQ-002 Parameter FIFO_DEPTH, default 8, number of entries (>=2); need not be a power of two.
REQ-003 Derived CNT_W = clog2(FIFO_DEPTH+1), width of count and thresholds.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  synchronous clear of contents, sampled each edge.
REQ-007 wr_en  in  1  write request; data_in  in  FIFO_WIDTH  write data.
REQ-008 rd_en  in  1  read request (pop).
REQ-009 af_thresh, ae_thresh  in  CNT_W  runtime almost-full / almost-empty thresholds.
REQ-010 data_out  out  FIFO_WIDTH  read data; rd_valid  out  1  data_out qualifier.
REQ-011 wr_ack, overflow, underflow  out  1  registered per-request status pulses.
REQ-012 full, empty, almostfull, almostempty  out  1  occupancy flags; count  out  CNT_W  occupancy.

Function
REQ-013 Write accepted when wr_en and (count<FIFO_DEPTH, or count==FIFO_DEPTH with a read accepted the same cycle).
REQ-014 Read accepted when rd_en and count>0; simultaneous write to empty FIFO: write accepted, read rejected.
REQ-015 count: +1 write-only, -1 read-only, unchanged on both or neither; never exceeds FIFO_DEPTH nor drops below 0.
REQ-016 Write and read pointers wrap from FIFO_DEPTH-1 to 0, including non-power-of-two depths.
REQ-017 wr_ack=1 in the cycle after an accepted write, else 0.
REQ-018 overflow=1 in the cycle after wr_en rejected, else 0; underflow=1 in the cycle after rd_en rejected, else 0.
REQ-019 full=(count==FIFO_DEPTH); empty=(count==0); combinational from registered count.
REQ-020 almostfull=(count>=af_thresh); almostempty=(count<=ae_thresh); thresholds may change any cycle, effect immediate.
REQ-021 af_thresh=0 -> almostfull constant 1; af_thresh>FIFO_DEPTH -> almostfull constant 0.
REQ-022 Rejected write leaves memory, pointers and count unchanged; rejected read leaves data_out unchanged.
REQ-023 flush: pointers and count to 0, status pulses 0 next cycle, wr_en/rd_en ignored that cycle; data_out retained.
REQ-024 Priority per edge: rst > flush > read/write.

Reset
REQ-025 On rst: pointers, count = 0; data_out = 0; wr_ack, overflow, underflow, rd_valid = 0.
REQ-026 After reset: empty=1, full=0, almostempty=1, almostfull=1 only if af_thresh==0.
REQ-027 Memory array contents are not reset; no output depends on unwritten entries.
REQ-028 rst mid-burst discards all stored data; first write after reset lands in entry 0.

Configuration
REQ-029 Macro SYNC_FIFO_FWFT_EN selects read mode.
REQ-030 Without SYNC_FIFO_FWFT_EN: data_out registered, updated to head word the cycle after an accepted read; rd_valid=1 that cycle only, else 0.
REQ-031 With SYNC_FIFO_FWFT_EN: data_out presents head word whenever empty=0 (zero read latency); rd_valid=!empty; rd_en pops head; data_out=0 while empty after reset.
REQ-032 All other requirements identical in both modes.

Verification (FIFO_WIDTH=16, FIFO_DEPTH=6, af_thresh=5, ae_thresh=1)
REQ-033 Reset, write 0x0001..0x0006 -> six wr_ack pulses, full=1, almostfull=1 from count 5, count=6.
REQ-034 Full, 7th write 0xDEAD -> overflow=1 next cycle, count=6, later reads return 0x0001..0x0006 in order, no 0xDEAD.
REQ-035 Full, wr_en+rd_en same cycle with 0x0007 -> wr_ack=1, count=6, 0x0001 popped; 200 random ops cross pointer wrap with scoreboard match.
REQ-036 Empty, wr_en 0x00AA + rd_en same cycle -> underflow=1, wr_ack=1, count=1, next read returns 0x00AA.
REQ-037 Count=4, flush=1 with wr_en=1 -> count=0, empty=1, wr_ack=0, next write lands in entry 0 and reads back correctly.
REQ-038 Read latency per mode: non-FWFT data 1 cycle after rd_en; FWFT data valid same cycle as empty falls.
